// File: rtl/sumador_pipe.sv
// ============================================================================
// sumador_pipe : registered ADD/SUB/ACC/LOAD unit with valid/ready handshake
// Optional: SUMADOR_SAT_EN enables saturating ADD/SUB/ACC.   Rev 1.0
// ============================================================================
`default_nettype none

module sumador_pipe #(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_ACC  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] opx, opy;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] raw, res;
  logic             cout, ovf_raw, carry_nxt;
  logic             xfer_in;

  assign in_ready = !out_valid || out_ready;
  assign xfer_in  = in_valid && in_ready;

  // SUB is a + ~b + 1 so one adder serves every operation
  always_comb begin
    opx = a;
    opy = '0;
    cin = 1'b0;
    case (op)
      OP_ADD:  begin opx = a;   opy = b;  cin = 1'b0; end
      OP_SUB:  begin opx = a;   opy = ~b; cin = 1'b1; end
      OP_ACC:  begin opx = acc; opy = a;  cin = 1'b0; end
      default: begin opx = a;   opy = '0; cin = 1'b0; end
    endcase
  end

  assign sum  = {1'b0, opx} + {1'b0, opy} + {{WIDTH{1'b0}}, cin};
  assign raw  = sum[WIDTH-1:0];
  assign cout = sum[WIDTH];

  always_comb begin
    ovf_raw   = 1'b0;
    carry_nxt = 1'b0;
    if (op != OP_LOAD) begin
      ovf_raw   = (opx[WIDTH-1] == opy[WIDTH-1]) && (raw[WIDTH-1] != opx[WIDTH-1]);
      carry_nxt = (op == OP_SUB) ? !cout : cout;
    end
  end

`ifdef SUMADOR_SAT_EN
  // Clamp direction follows the first operand's sign when overflowing
  always_comb begin
    res = raw;
    if (op != OP_LOAD) begin
      if (SIGNED != 0) begin
        if (ovf_raw)
          res = opx[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end else if (carry_nxt) begin
        res = (op == OP_SUB) ? '0 : '1;
      end
    end
  end
`else
  assign res = raw;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      acc       <= '0;
    end else if (xfer_in) begin
      out_valid <= 1'b1;
      result    <= res;
      carry     <= carry_nxt;
      overflow  <= ovf_raw;
      zero      <= (res == '0);
      if (op == OP_ACC || op == OP_LOAD)
        acc <= res;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire
